// File: rtl/pmcd_seq_pkg.sv
`default_nettype none
// ============================================================================
// pmcd_seq_pkg : shared types and widths for the PMCD reset/release sequencer
// Revision 1.0
// ============================================================================
package pmcd_seq_pkg;

  localparam int CNT_W    = 16;
  localparam int RELOCK_W = 8;

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_HOLD_RST  = 3'd1,
    S_REL_DLY   = 3'd2,
    S_REL       = 3'd3,
    S_RUN       = 3'd4,
    S_FAULT     = 3'd5
  } state_e;

  // Load value so that a state lasting N cycles exits when the counter hits 0.
  function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pmcd_lock_filter.sv
`default_nettype none
// ============================================================================
// pmcd_lock_filter : 2-flop LOCKED synchronizer and consecutive-high qualifier
// Revision 1.0
// ============================================================================
module pmcd_lock_filter #(
  parameter int LOCK_FILTER = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic locked_i,
  output logic lock_ok_o
);

  localparam int             RUN_W    = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_FILTER - 1);

  logic             meta_q;
  logic             sync_q;
  logic [RUN_W-1:0] run_q;
  logic             ok_q;

  // Qualification is slow on rise, but a single low sample drops lock at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      run_q  <= '0;
      ok_q   <= 1'b0;
    end else begin
      meta_q <= locked_i;
      sync_q <= meta_q;
      if (!sync_q) begin
        run_q <= '0;
        ok_q  <= 1'b0;
      end else if (run_q == RUN_LAST) begin
        ok_q  <= 1'b1;
      end else begin
        run_q <= run_q + 1'b1;
      end
    end
  end

  assign lock_ok_o = ok_q;

endmodule
`default_nettype wire

// File: rtl/pmcd_seq_ctrl.sv
`default_nettype none
// ============================================================================
// pmcd_seq_ctrl : waits for qualified DCM lock, sequences PMCD RST then REL
// Revision 1.0
// ============================================================================
module pmcd_seq_ctrl
  import pmcd_seq_pkg::*;
#(
  parameter int    RST_CYCLES  = 16,
  parameter int    LOCK_FILTER = 8,
  parameter int    REL_DELAY   = 4,
  parameter int    REL_PULSE   = 2,
  parameter int    TIMEOUT     = 65535,
  parameter string EN_REL      = "TRUE"
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                LOCKED,
  input  logic                SYNC_REQ,
  output logic                PMCD_RST,
  output logic                PMCD_REL,
  output logic                READY,
  output logic                SYNC_ACK,
  output logic                FAULT,
  output logic [2:0]          STATE,
  output logic [RELOCK_W-1:0] RELOCK_CNT
);

  localparam bit               USE_REL      = (EN_REL != "FALSE");
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                pend_q, pend_d;
  logic [RELOCK_W-1:0] relock_q, relock_d;
  logic                ack_q, ack_d;
  logic                prst_q, rel_q, ready_q, fault_q;
  logic                lock_ok;
  logic                in_seq;
  logic                sync_hit;

  pmcd_lock_filter #(
    .LOCK_FILTER (LOCK_FILTER)
  ) u_lock_filter (
    .clk_i     (CLK),
    .rst_i     (RST),
    .locked_i  (LOCKED),
    .lock_ok_o (lock_ok)
  );

  assign in_seq   = (state_q == S_HOLD_RST) || (state_q == S_REL_DLY) ||
                    (state_q == S_REL)      || (state_q == S_RUN);
  // The ACK cycle itself never re-triggers; the requester drops on the next.
  assign sync_hit = SYNC_REQ && !ack_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    relock_d = relock_q;
    ack_d    = 1'b0;

    if (in_seq && !lock_ok) begin
      state_d = S_WAIT_LOCK;
      cnt_d   = '0;
      if (relock_q != {RELOCK_W{1'b1}}) begin
        relock_d = relock_q + 1'b1;
      end
      if ((state_q == S_RUN) && sync_hit) begin
        pend_d = 1'b1;
      end
    end else begin
      case (state_q)
        S_WAIT_LOCK: begin
          if (lock_ok) begin
            state_d = S_HOLD_RST;
            cnt_d   = cnt_load(RST_CYCLES);
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d = S_FAULT;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + 1'b1;
          end
        end
        S_HOLD_RST: begin
          if (cnt_q == '0) begin
            if (USE_REL) begin
              state_d = S_REL_DLY;
              cnt_d   = cnt_load(REL_DELAY);
            end else begin
              state_d = S_RUN;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_REL_DLY: begin
          if (cnt_q == '0) begin
            state_d = S_REL;
            cnt_d   = cnt_load(REL_PULSE);
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_REL: begin
          if (cnt_q == '0) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_RUN: begin
          if (sync_hit) begin
            state_d = S_HOLD_RST;
            cnt_d   = cnt_load(RST_CYCLES);
            pend_d  = 1'b1;
          end
        end
        S_FAULT: begin
          if (SYNC_REQ) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
            pend_d  = 1'b1;
          end
        end
        default: begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end
      endcase
    end

    if ((state_d == S_RUN) && (state_q != S_RUN) && pend_q) begin
      ack_d  = 1'b1;
      pend_d = 1'b0;
    end
  end

  // Outputs are decoded from the next state so they line up with STATE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_WAIT_LOCK;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      relock_q <= '0;
      ack_q    <= 1'b0;
      prst_q   <= 1'b1;
      rel_q    <= 1'b0;
      ready_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      relock_q <= relock_d;
      ack_q    <= ack_d;
      prst_q   <= (state_d == S_WAIT_LOCK) || (state_d == S_HOLD_RST) ||
                  (state_d == S_FAULT);
      rel_q    <= (state_d == S_REL);
      ready_q  <= (state_d == S_RUN);
      fault_q  <= (state_d == S_FAULT);
    end
  end

  assign PMCD_RST   = prst_q;
  assign PMCD_REL   = rel_q;
  assign READY      = ready_q;
  assign SYNC_ACK   = ack_q;
  assign FAULT      = fault_q;
  assign STATE      = state_q;
  assign RELOCK_CNT = relock_q;

endmodule
`default_nettype wire

// File: tb/tb_pmcd_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pmcd_seq_ctrl : scoreboard bench, two sequencer configurations in parallel
// Revision 1.0
// ============================================================================
module tb_pmcd_seq_ctrl;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       locked = 1'b0;
  logic [1:0] sreq   = '0;
  logic [1:0] prst, rel, rdy, ack, flt;
  logic [2:0] st   [2];
  logic [7:0] rcnt [2];

  always #5 clk = ~clk;

  pmcd_seq_ctrl #(
    .TIMEOUT (100)
  ) u_dut_a (
    .CLK(clk), .RST(rst), .LOCKED(locked), .SYNC_REQ(sreq[0]),
    .PMCD_RST(prst[0]), .PMCD_REL(rel[0]), .READY(rdy[0]), .SYNC_ACK(ack[0]),
    .FAULT(flt[0]), .STATE(st[0]), .RELOCK_CNT(rcnt[0])
  );

  pmcd_seq_ctrl #(
    .RST_CYCLES(5), .LOCK_FILTER(3), .TIMEOUT(40), .EN_REL("FALSE")
  ) u_dut_b (
    .CLK(clk), .RST(rst), .LOCKED(locked), .SYNC_REQ(sreq[1]),
    .PMCD_RST(prst[1]), .PMCD_REL(rel[1]), .READY(rdy[1]), .SYNC_ACK(ack[1]),
    .FAULT(flt[1]), .STATE(st[1]), .RELOCK_CNT(rcnt[1])
  );

  typedef struct packed {
    logic       prst;
    logic       rel;
    logic       rdy;
    logic       ack;
    logic       flt;
    logic [2:0] st;
    logic [7:0] cnt;
  } obs_t;

  obs_t sbq [2][$];
  int   vectors = 0;
  int   errors  = 0;

  function automatic int p_rc(input int i); return (i == 0) ? 16  : 5;  endfunction
  function automatic int p_lf(input int i); return (i == 0) ? 8   : 3;  endfunction
  function automatic int p_rd(input int i); return 4;                   endfunction
  function automatic int p_rp(input int i); return 2;                   endfunction
  function automatic int p_to(input int i); return (i == 0) ? 100 : 40; endfunction
  function automatic bit p_er(input int i); return (i == 0);            endfunction

  // Reference model: phase 0 waiting, 1 sequencing (t = cycles since HOLD_RST
  // entry), 2 faulted. The visible state is derived from t and the timing rules.
  int m_ph [2], m_t [2], m_wc [2], m_rel [2], m_run [2];
  bit m_ok [2], m_d1 [2], m_d2 [2], m_pend [2], m_ack [2], m_flt [2];
  bit want [2];
  bit extra = 1'b0;
  int n_ack [2];

  function automatic int mstate(input int i);
    int t;
    t = m_t[i];
    if (m_ph[i] == 0) return 0;
    if (m_ph[i] == 2) return 5;
    if (t < p_rc(i)) return 1;
    if (!p_er(i)) return 4;
    if (t < p_rc(i) + p_rd(i)) return 2;
    if (t < p_rc(i) + p_rd(i) + p_rp(i)) return 3;
    return 4;
  endfunction

  function automatic obs_t mexp(input int i);
    obs_t o;
    int   s;
    s      = mstate(i);
    o.prst = (s == 0) || (s == 1) || (s == 5);
    o.rel  = (s == 3);
    o.rdy  = (s == 4);
    o.ack  = m_ack[i];
    o.flt  = m_flt[i];
    o.st   = 3'(s);
    o.cnt  = 8'(m_rel[i]);
    return o;
  endfunction

  task automatic mstep(input int i, input bit r, input bit lk, input bit sr);
    int s0;
    bit ackp;
    bit hit;
    if (r) begin
      m_ph[i] = 0; m_t[i] = 0; m_wc[i] = 0; m_rel[i] = 0; m_run[i] = 0;
      m_ok[i] = 0; m_d1[i] = 0; m_d2[i] = 0; m_pend[i] = 0; m_ack[i] = 0; m_flt[i] = 0;
    end else begin
      s0       = mstate(i);
      ackp     = m_ack[i];
      m_ack[i] = 0;
      hit      = (s0 == 4) && sr && !ackp;
      case (m_ph[i])
        0: begin
          if (m_ok[i]) begin
            m_ph[i] = 1; m_t[i] = 0;
          end else if (m_wc[i] + 1 == p_to(i)) begin
            m_ph[i] = 2; m_flt[i] = 1;
          end else begin
            m_wc[i]++;
          end
        end
        2: begin
          if (sr) begin
            m_ph[i] = 0; m_wc[i] = 0; m_flt[i] = 0; m_pend[i] = 1;
          end
        end
        default: begin
          if (hit) m_pend[i] = 1;
          if (!m_ok[i]) begin
            m_ph[i] = 0; m_wc[i] = 0;
            if (m_rel[i] < 255) m_rel[i]++;
          end else if (hit) begin
            m_t[i] = 0;
          end else if (s0 != 4) begin
            m_t[i]++;
            if (mstate(i) == 4 && m_pend[i]) begin
              m_ack[i] = 1; m_pend[i] = 0;
            end
          end
        end
      endcase
      // LOCKED seen two cycles late; lock_ok once LOCK_FILTER highs in a row
      m_run[i] = m_d2[i] ? m_run[i] + 1 : 0;
      m_ok[i]  = (m_run[i] >= p_lf(i));
      m_d2[i]  = m_d1[i];
      m_d1[i]  = lk;
    end
  endtask

  function automatic obs_t dut_obs(input int i);
    obs_t o;
    o.prst = prst[i]; o.rel = rel[i]; o.rdy = rdy[i]; o.ack = ack[i];
    o.flt  = flt[i];  o.st  = st[i];  o.cnt = rcnt[i];
    return o;
  endfunction

  task automatic check(input string name, input obs_t a, input obs_t e);
    vectors++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s t=%0t: got rst/rel/rdy/ack/flt=%b%b%b%b%b st=%0d relock=%0d, expected %b%b%b%b%b st=%0d relock=%0d",
               name, $time, a.prst, a.rel, a.rdy, a.ack, a.flt, a.st, a.cnt,
               e.prst, e.rel, e.rdy, e.ack, e.flt, e.st, e.cnt);
    end
  endtask

  task automatic chk_val(input string name, input int a, input int e);
    vectors++;
    if (a != e) begin
      errors++;
      $display("FAIL %s t=%0t: got %0d, expected %0d", name, $time, a, e);
    end
  endtask

  // One cycle of stimulus: drive at the falling edge, predict the next rise.
  task automatic step(input bit r, input bit lk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (ack[i]) n_ack[i]++;
      if (r) want[i] = 1'b0;
      else if (m_ack[i]) want[i] = extra && ($urandom_range(7) == 0);
    end
    rst    = r;
    locked = lk;
    sreq   = {want[1], want[0]};
    for (int i = 0; i < 2; i++) begin
      mstep(i, r, lk, want[i]);
      sbq[i].push_back(mexp(i));
    end
  endtask

  task automatic wait_state(input int i, input int s, input int budget, input bit lk);
    int n;
    n = 0;
    while (mstate(i) != s && n < budget) begin
      step(1'b0, lk);
      n++;
    end
    chk_val("wait_state_budget", mstate(i), s);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < 2; i++) begin
        if (sbq[i].size() > 0) check(i == 0 ? "scoreboard_a" : "scoreboard_b", dut_obs(i), sbq[i].pop_front());
      end
    end
  end

  initial begin
    int base;
    bit lk_r;
    for (int i = 0; i < 2; i++) begin
      mstep(i, 1'b1, 1'b0, 1'b0);
      want[i]  = 1'b0;
      n_ack[i] = 0;
    end

    // power-up with LOCKED rising at cycle 10
    repeat (3)  step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);
    repeat (60) step(1'b0, 1'b1);

    // lock timeout, lock alone does not clear FAULT, re-sync does
    repeat (120) step(1'b0, 1'b0);
    chk_val("fault_a", flt[0], 1);
    chk_val("fault_state_a", st[0], 5);
    repeat (20) step(1'b0, 1'b1);
    want[0] = 1'b1; want[1] = 1'b1;
    repeat (80) step(1'b0, 1'b1);
    chk_val("fault_cleared_a", flt[0], 0);
    chk_val("ready_after_resync_a", rdy[0], 1);

    // repeated lock loss drives the saturating counter
    for (int k = 0; k < 300; k++) begin
      repeat ($urandom_range(2, 1))   step(1'b0, 1'b0);
      repeat ($urandom_range(45, 14)) step(1'b0, 1'b1);
    end
    chk_val("relock_sat_a", rcnt[0], 255);
    chk_val("relock_sat_b", rcnt[1], 255);

    // glitchy lock never qualifies an 8-cycle filter
    repeat (4) step(1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      repeat (7) step(1'b0, 1'b1);
      step(1'b0, 1'b0);
    end
    chk_val("glitch_state_a", st[0], 0);
    chk_val("glitch_prst_a", prst[0], 1);

    // re-sync request, then lock loss during REL_DLY
    repeat (60) step(1'b0, 1'b1);
    base    = n_ack[0];
    want[0] = 1'b1;
    wait_state(0, 2, 60, 1'b1);
    step(1'b0, 1'b0);
    repeat (80) step(1'b0, 1'b1);
    chk_val("single_ack_a", n_ack[0] - base, 1);

    // randomized lock and request traffic
    extra = 1'b1;
    lk_r  = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(39) == 0) lk_r = !lk_r;
      for (int i = 0; i < 2; i++) begin
        if (!want[i] && $urandom_range(59) == 0) want[i] = 1'b1;
      end
      step(1'b0, lk_r);
    end
    extra = 1'b0;

    // asynchronous reset while PMCD_REL is high
    want[0] = 1'b1; want[1] = 1'b1;
    wait_state(0, 3, 300, 1'b1);
    step(1'b1, 1'b1);
    #1;
    chk_val("async_rst_rel_a", rel[0], 0);
    chk_val("async_rst_prst_a", prst[0], 1);
    check("async_rst_b", dut_obs(1), mexp(1));
    repeat (2)  step(1'b1, 1'b1);
    repeat (60) step(1'b0, 1'b1);

    @(posedge clk);
    #3;
    chk_val("scoreboard_drained", sbq[0].size() + sbq[1].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pmcd_seq_ctrl.md
# pmcd_seq_ctrl

Reset/release sequencer for a phase-matched clock divider (PMCD) fed by a DCM. It waits for a qualified DCM `LOCKED`, holds the PMCD in reset for a programmed time, then pulses `REL` so all divided outputs start phase-aligned. It re-runs the sequence on lock loss or on a software re-sync request, and flags a fault if lock never arrives. It sits beside the PMCD in the clock-management tile and runs on a free-running reference clock, not on any PMCD output.

## Interface
Parameters:
- `RST_CYCLES`, 16: cycles `PMCD_RST` is held in HOLD_RST (≥1).
- `LOCK_FILTER`, 8: consecutive synchronized-high cycles of `LOCKED` required to qualify lock (≥1).
- `REL_DELAY`, 4: cycles between `PMCD_RST` falling and `PMCD_REL` rising (≥1).
- `REL_PULSE`, 2: width of the `PMCD_REL` pulse, in cycles (≥1).
- `TIMEOUT`, 65535: WAIT_LOCK cycles before FAULT (≤65535).
- `EN_REL`, "TRUE": "FALSE" skips the REL_DLY and REL states; `PMCD_REL` then stays 0.

Ports:
- `CLK`  in  1  free-running reference clock.
- `RST`  in  1  reset; asynchronous, active-high.
- `LOCKED`  in  1  DCM lock, asynchronous; synchronized internally by 2 flops.
- `SYNC_REQ`  in  1  re-sync request, level; held until `SYNC_ACK`.
- `PMCD_RST`  out  1  to PMCD `RST`.
- `PMCD_REL`  out  1  to PMCD `REL`.
- `READY`  out  1  PMCD outputs valid and aligned.
- `SYNC_ACK`  out  1  one-cycle pulse: requested re-sync complete.
- `FAULT`  out  1  lock timeout, sticky.
- `STATE`  out  3  current state encoding.
- `RELOCK_CNT`  out  8  number of lock-loss events, saturating.

## Operation
State encoding:
- 0 WAIT_LOCK, 1 HOLD_RST, 2 REL_DLY, 3 REL, 4 RUN, 5 FAULT.

Lock qualification:
- `lock_ok` is the filtered lock.
- `lock_ok` rises after the synchronized `LOCKED` has been high for `LOCK_FILTER` consecutive cycles.
- `lock_ok` falls the cycle after the synchronized `LOCKED` is sampled low. There is no debounce on loss.

Reset values (all outputs registered):
- state WAIT_LOCK, `PMCD_RST`=1, `PMCD_REL`=0, `READY`=0, `SYNC_ACK`=0, `FAULT`=0, `RELOCK_CNT`=0.
- The internal sync-pending flag resets to 0.

Transitions:
- WAIT_LOCK: `PMCD_RST`=1 and the timeout counter increments.
  - `lock_ok` → HOLD_RST.
  - Counter reaches `TIMEOUT` → FAULT, with `FAULT`=1.
- HOLD_RST: `PMCD_RST`=1 for exactly `RST_CYCLES` cycles.
  - Then → REL_DLY, or → RUN if `EN_REL`="FALSE".
- REL_DLY: `PMCD_RST`=0 for `REL_DELAY` cycles, then → REL.
- REL: `PMCD_REL`=1 for `REL_PULSE` cycles, then → RUN.
- RUN: `READY`=1.
  - If the pending flag is set on entry, `SYNC_ACK` pulses on the first RUN cycle and the flag clears.
  - `SYNC_REQ`=1 (with `SYNC_ACK`=0) → HOLD_RST, pending flag set, `READY`=0.
- FAULT: `PMCD_RST`=1.
  - `SYNC_REQ` → WAIT_LOCK, `FAULT` cleared, pending flag set.
  - `lock_ok` alone does not exit FAULT.

Lock loss:
- `!lock_ok` in HOLD_RST, REL_DLY, REL or RUN → WAIT_LOCK.
- `PMCD_RST`=1, `PMCD_REL`=0 and `READY`=0 on the next cycle.
- `RELOCK_CNT` increments and saturates at 255.

Simultaneous events:
- Lock loss and `SYNC_REQ` in the same cycle: lock loss wins, the pending flag is still set, and the ACK is issued on the next RUN entry.
- `SYNC_REQ` is ignored in WAIT_LOCK, HOLD_RST, REL_DLY and REL, but a request already pending is kept.
- Requester protocol: drop `SYNC_REQ` the cycle after `SYNC_ACK`. A request still high one cycle after ACK starts a new sync.

Counter width:
- One shared 16-bit down/up counter is used for every state; it is reloaded on each state entry.

## Timing
Relative to cycle T where the state becomes HOLD_RST:
- `PMCD_RST` is 1 for cycles T..T+`RST_CYCLES`-1 and 0 from T+`RST_CYCLES`.
- `PMCD_REL` is 1 for cycles T+`RST_CYCLES`+`REL_DELAY` .. +`REL_PULSE`-1.
- `READY` rises the cycle after `PMCD_REL` falls.
- With `EN_REL`="FALSE", `READY` rises at T+`RST_CYCLES`.

Lock latency:
- Raw `LOCKED` rise → `lock_ok` takes 2 synchronizer cycles + `LOCK_FILTER` cycles.
- `lock_ok` → HOLD_RST takes 1 cycle.

Lock-loss latency:
- Raw `LOCKED` fall → `PMCD_RST`=1 / `READY`=0 takes at most 4 cycles.

Reset:
- Asynchronous `RST` mid-sequence forces all reset values immediately.

## Structure
- Package `pmcd_seq_pkg` holds:
  - the state enum (3-bit) above;
  - `CNT_W`=16;
  - `RELOCK_W`=8.
- Sub-module `pmcd_lock_filter`:
  - 2-flop synchronizer plus consecutive-high counter;
  - parameter `LOCK_FILTER`;
  - output `lock_ok`.
- The FSM, shared counter and output registers live in `pmcd_seq_ctrl`.

## Test plan
- Power-up, defaults: `LOCKED` rises at cycle 10 → `PMCD_RST` held 16 cycles after HOLD_RST entry, `PMCD_REL` high 2 cycles starting 4 cycles after `PMCD_RST` falls, `READY`=1 the following cycle.
- Timeout, `TIMEOUT`=100 with `LOCKED`=0 → `FAULT`=1 and `STATE`=5 at cycle 100. Later `SYNC_REQ` with `LOCKED`=1 → full sequence, then `SYNC_ACK` one pulse, `FAULT`=0.
- Lock loss in RUN: `LOCKED` dropped for 1 cycle → `READY`=0 and `PMCD_RST`=1 within 4 cycles, `RELOCK_CNT`=1, full re-sequence. After 300 losses, `RELOCK_CNT`=255.
- Glitchy lock: `LOCKED` high 7 cycles, low 1, repeated (`LOCK_FILTER`=8) → remains in WAIT_LOCK, `PMCD_RST`=1.
- Re-sync in RUN with loss mid-sequence: `SYNC_REQ`, then `LOCKED` low during REL_DLY → back to WAIT_LOCK; after relock, exactly one `SYNC_ACK` on RUN entry.
- `EN_REL`="FALSE": `PMCD_REL` never 1, `READY` rises exactly `RST_CYCLES` after HOLD_RST entry. Async `RST` mid-REL → `PMCD_REL`=0 and `PMCD_RST`=1 immediately.
